// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and constants for addsub_serial (saturation helpers under ADDSUB_SAT_EN)
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic cout;
    logic ovr;
    logic zero;
    logic neg;
  } flags_t;
`ifdef ADDSUB_SAT_EN
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction
`endif
endpackage

// File: rtl/addsub_digit.sv
// addsub_digit: combinational DIGIT-bit adder also exposing the carry into its top bit
module addsub_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  assign c_msb = sum[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];
endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial two's-complement add/sub with valid/ready handshakes.
// Define ADDSUB_SAT_EN to saturate r on signed overflow.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             ovr,
  output logic             zero,
  output logic             neg
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  generate
    if (WIDTH < 2 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_cfg
      $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate
`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));
`endif
  state_t           state, nxt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nx, r_fin;
  logic [DIGIT-1:0] sum;
  logic [CW-1:0]    cnt;
  logic             carry, dc, dm, ov, last;
  flags_t           fl;
  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .cin  (carry),
    .sum  (sum),
    .cout (dc),
    .c_msb(dm)
  );
  always_comb begin
    last = cnt == CW'(N - 1);
    r_nx = (r_sh >> DIGIT) | (WIDTH'(sum) << (WIDTH - DIGIT));
    ov   = dm ^ dc;
`ifdef ADDSUB_SAT_EN
    // raw MSB set on overflow means two positives wrapped negative
    r_fin = ov ? (r_nx[WIDTH-1] ? SMAX : SMIN) : r_nx;
`else
    r_fin = r_nx;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  always_comb
    nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
          state == RUN  ? (last ? DONE : RUN) :
                          (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    cout      = fl.cout;
    ovr       = fl.ovr;
    zero      = fl.zero;
    neg       = fl.neg;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      r     <= '0;
      fl    <= '0;
    end else if (state == IDLE && in_valid) begin
      a_sh  <= a;
      b_sh  <= b ^ {WIDTH{sub}};
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      r_sh  <= r_nx;
      carry <= dc;
      cnt   <= cnt + CW'(1);
      if (last) begin
        r  <= r_fin;
        fl <= {dc, ov, ~|r_fin, r_fin[WIDTH-1]};
      end
    end
  end
endmodule
